// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC sequencing, one-cycle imem interface, and a small FIFO ahead of decode.
// Optional static branch prediction (JAL / backward branches) is compiled in with macro FETCH_PREDICT_EN.
module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h00000040,
   parameter int          IMEM_AW  = 8,
   parameter int          QDEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       redirect,
   input  logic [31:0]                redirect_target,
   output logic                       imem_req,
   output logic [IMEM_AW-1:0]         imem_addr,
   input  logic [31:0]                imem_data,
   input  logic                       id_ready,
   output logic                       id_valid,
   output logic [31:0]                id_pc,
   output logic [31:0]                id_ins,
   output logic                       id_ins_misalign,
   output logic                       id_predict_taken,
   output logic [$clog2(QDEPTH):0]    q_count
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(QDEPTH);

   logic [31:0]   r_pc;
   logic [31:0]   r_req_pc;
   logic          r_inflight;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;

   logic [31:0]   r_q_pc   [QDEPTH];
   logic [31:0]   r_q_ins  [QDEPTH];
   logic          r_q_mis  [QDEPTH];
   logic          r_q_pred [QDEPTH];

   logic [CW:0]   w_occ;
   logic          w_req;
   logic          w_push;
   logic          w_pop;
   logic          w_mis;
   logic          w_pred;
   logic [31:0]   w_pred_target;
   logic [31:0]   w_pc_nxt;

   // Outstanding fetches count against capacity so a returning response always has a slot.
   assign w_occ    = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_req    = !rst && !redirect && (w_occ < DEPTH_L);
   assign w_push   = r_inflight && !redirect;
   assign w_pop    = id_valid && id_ready;
   assign w_mis    = (r_req_pc[1:0] != 2'b00);

`ifdef FETCH_PREDICT_EN
   logic        w_is_jal;
   logic        w_is_bneg;
   logic [31:0] w_j_imm;
   logic [31:0] w_b_imm;

   assign w_is_jal      = (imem_data[6:0] == 7'b1101111);
   assign w_is_bneg     = (imem_data[6:0] == 7'b1100011) && imem_data[31];
   assign w_j_imm       = {{11{imem_data[31]}}, imem_data[31], imem_data[19:12],
                           imem_data[20], imem_data[30:21], 1'b0};
   assign w_b_imm       = {{19{imem_data[31]}}, imem_data[31], imem_data[7],
                           imem_data[30:25], imem_data[11:8], 1'b0};
   assign w_pred        = w_push && !w_mis && (w_is_jal || w_is_bneg);
   assign w_pred_target = r_req_pc + (w_is_jal ? w_j_imm : w_b_imm);
`else
   assign w_pred        = 1'b0;
   assign w_pred_target = r_req_pc;
`endif

   // Next-PC priority: redirect, then prediction, then sequential advance on issue.
   always_comb begin
      w_pc_nxt = r_pc;
      if (redirect) begin
         w_pc_nxt = redirect_target;
      end else if (w_pred) begin
         w_pc_nxt = w_pred_target;
      end else if (w_req) begin
         w_pc_nxt = r_pc + 32'd4;
      end else begin
         w_pc_nxt = r_pc;
      end
   end

   // PC, in-flight tracking and queue pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_req_pc   <= RESET_PC;
         r_inflight <= 1'b0;
         r_count    <= {CW{1'b0}};
         r_head     <= {PW{1'b0}};
         r_tail     <= {PW{1'b0}};
      end else begin
         r_pc       <= w_pc_nxt;
         r_inflight <= w_req && !w_pred;
         if (w_req) begin
            r_req_pc <= r_pc;
         end
         if (redirect) begin
            r_count <= {CW{1'b0}};
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
         end else begin
            if (w_push) begin
               r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
               r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Queue entry storage; contents need no reset because id_valid qualifies them.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_q_pc[r_tail]   <= r_req_pc;
         r_q_ins[r_tail]  <= imem_data;
         r_q_mis[r_tail]  <= w_mis;
         r_q_pred[r_tail] <= w_pred;
      end
   end

   assign imem_req         = w_req;
   assign imem_addr        = r_pc[IMEM_AW+1:2];
   assign q_count          = r_count;
   assign id_valid         = (r_count != {CW{1'b0}});
   assign id_pc            = r_q_pc[r_head];
   assign id_ins           = r_q_ins[r_head];
   assign id_ins_misalign  = r_q_mis[r_head];
   assign id_predict_taken = id_valid && r_q_pred[r_head];

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: reset-release vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model (prediction cases need FETCH_PREDICT_EN).
module tb_fetch_queue;

   localparam int          QDEPTH   = 4;
   localparam int          IMEM_AW  = 8;
   localparam logic [31:0] RESET_PC = 32'h00000040;
   localparam logic [31:0] JAL_100  = 32'h1000006F;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_ins;
   logic        id_ins_misalign;
   logic        id_predict_taken;
   logic [2:0]  q_count;

   fetch_queue #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW), .QDEPTH(QDEPTH)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_target(redirect_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
      .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_ins(id_ins),
      .id_ins_misalign(id_ins_misalign), .id_predict_taken(id_predict_taken),
      .q_count(q_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: data appears in the cycle after the strobe, garbage otherwise.
   logic [31:0] mem [0:255];
   logic        r_mreq;
   logic [7:0]  r_maddr;
   always @(posedge clk) begin
      r_mreq  <= imem_req;
      r_maddr <= imem_addr;
   end
   assign imem_data = r_mreq ? mem[r_maddr] : 32'hDEADBEEF;

   typedef struct packed { logic [31:0] pc; logic [31:0] ins; logic mis; logic pred; } ent_t;
   typedef struct { logic [31:0] pc; logic pred; } pop_t;
   typedef struct { bit rst; bit rdy; int q; bit req; logic [7:0] addr; bit valid; logic [31:0] pc; } vec_t;

   ent_t        mq[$];
   pop_t        dut_pops[$];
   logic [31:0] m_pc;
   logic [31:0] m_ipc;
   bit          m_inf;
   bit          m_known;
   int          checks;
   int          errors;
   vec_t        tbl [12];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   function automatic bit m_predict(input logic [31:0] pc, input logic [31:0] ins, output logic [31:0] tgt);
      int  imm;
      bit  en;
      bit  jal;
      bit  bneg;
`ifdef FETCH_PREDICT_EN
      en = 1'b1;
`else
      en = 1'b0;
`endif
      jal  = (ins[6:0] == 7'b1101111);
      bneg = (ins[6:0] == 7'b1100011) && ins[31];
      imm  = 0;
      if (jal) begin
         if (ins[31]) imm = -1048576;
         imm += int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      end else begin
         if (ins[31]) imm = -4096;
         imm += int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      end
      tgt = pc + 32'(imm);
      return en && (pc[1:0] == 2'b00) && (jal || bneg);
   endfunction

   // Apply inputs, compare the DUT against the model, then advance the model by one cycle.
   task automatic drive(input bit r, input bit rd, input logic [31:0] tgt, input bit rdy);
      bit          exp_req;
      bit          p;
      logic [31:0] ptgt;
      ent_t        e;
      rst = r; redirect = rd; redirect_target = tgt; id_ready = rdy;
      #1;
      exp_req = !r && !rd && ((mq.size() + int'(m_inf)) < QDEPTH);
      if (m_known) begin
         chk("imem_req", imem_req, exp_req);
         chk("imem_addr", imem_addr, m_pc[9:2]);
         chk("q_count", q_count, mq.size());
         chk("id_valid", id_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("id_pc", id_pc, mq[0].pc);
            chk("id_ins", id_ins, mq[0].ins);
            chk("id_misalign", id_ins_misalign, mq[0].mis);
            chk("id_predict", id_predict_taken, mq[0].pred);
         end else begin
            chk("id_predict_empty", id_predict_taken, 1'b0);
         end
      end
      if (id_valid && id_ready) dut_pops.push_back('{id_pc, id_predict_taken});
      if (r) begin
         mq.delete(); m_pc = RESET_PC; m_inf = 1'b0; m_known = 1'b1;
      end else if (rd) begin
         mq.delete(); m_pc = tgt; m_inf = 1'b0;
      end else begin
         p = 1'b0;
         if (mq.size() != 0 && rdy) void'(mq.pop_front());
         if (m_inf) begin
            e.pc = m_ipc; e.ins = mem[m_ipc[9:2]]; e.mis = (m_ipc[1:0] != 2'b00);
            p = m_predict(m_ipc, e.ins, ptgt);
            e.pred = p;
            mq.push_back(e);
         end
         if (p) begin
            m_pc = ptgt; m_inf = 1'b0;
         end else if (exp_req) begin
            m_ipc = m_pc; m_pc = m_pc + 32'd4; m_inf = 1'b1;
         end else begin
            m_inf = 1'b0;
         end
      end
   endtask

   task automatic step(input bit r, input bit rd, input logic [31:0] tgt, input bit rdy);
      drive(r, rd, tgt, rdy);
      @(negedge clk);
   endtask

   initial begin
      int  n0;
      bit  cap;
      checks = 0; errors = 0; m_known = 1'b0; m_inf = 1'b0; m_pc = RESET_PC; m_ipc = RESET_PC;
      rst = 1'b1; redirect = 1'b0; redirect_target = 32'd0; id_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = (32'(i) << 12) | 32'h00000013;

      //           rst   rdy   q  req  addr   valid pc
      tbl[0]  = '{1'b1, 1'b1, 0, 1'b0, 8'h10, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 1'b1, 0, 1'b1, 8'h10, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 1'b1, 0, 1'b1, 8'h11, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 1'b1, 1, 1'b1, 8'h12, 1'b1, 32'h40};
      tbl[4]  = '{1'b0, 1'b1, 1, 1'b1, 8'h13, 1'b1, 32'h44};
      tbl[5]  = '{1'b0, 1'b0, 1, 1'b1, 8'h14, 1'b1, 32'h48};
      tbl[6]  = '{1'b0, 1'b0, 2, 1'b1, 8'h15, 1'b1, 32'h48};
      tbl[7]  = '{1'b0, 1'b0, 3, 1'b0, 8'h16, 1'b1, 32'h48};
      tbl[8]  = '{1'b0, 1'b0, 4, 1'b0, 8'h16, 1'b1, 32'h48};
      tbl[9]  = '{1'b0, 1'b1, 4, 1'b0, 8'h16, 1'b1, 32'h48};
      tbl[10] = '{1'b0, 1'b1, 3, 1'b1, 8'h16, 1'b1, 32'h4C};
      tbl[11] = '{1'b0, 1'b1, 2, 1'b1, 8'h17, 1'b1, 32'h50};

      @(negedge clk);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].rst, 1'b0, 32'd0, tbl[i].rdy);
         chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
         chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
         chk($sformatf("tbl%0d_q", i), q_count, tbl[i].q);
         chk($sformatf("tbl%0d_valid", i), id_valid, tbl[i].valid);
         if (tbl[i].valid) chk($sformatf("tbl%0d_pc", i), id_pc, tbl[i].pc);
         if (tbl[i].rst) chk($sformatf("tbl%0d_pred", i), id_predict_taken, 1'b0);
         @(negedge clk);
      end

      // Simultaneous push and pop at QDEPTH-1.
      step(1'b0, 1'b0, 32'd0, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      chk("pp3_q_before", q_count, 3);
      chk("pp3_head_before", id_pc, 32'h54);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      chk("pp3_q_after", q_count, 3);
      chk("pp3_head_after", id_pc, 32'h58);
      @(negedge clk);

      // Stall decode for 10 cycles, then resume and confirm contiguous delivery.
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b0, 32'd0, 1'b0);
         if (k == 9) begin
            chk("stall_q_sat", q_count, QDEPTH);
            chk("stall_no_req", imem_req, 1'b0);
         end
         @(negedge clk);
      end
      n0 = dut_pops.size();
      for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 32'd0, 1'b1);
      chk("resume_pop_count", (dut_pops.size() - n0) >= 8, 1'b1);
      for (int j = n0 + 1; j < dut_pops.size(); j++)
         chk("resume_order", dut_pops[j].pc, dut_pops[j-1].pc + 32'd4);

      // Redirect with three entries queued.
      for (int k = 0; k < 8; k++) begin
         if (q_count == 3'd3) break;
         step(1'b0, 1'b0, 32'd0, q_count > 3'd3);
      end
      chk("redir_pre_q", q_count, 3);
      step(1'b0, 1'b1, 32'h200, 1'b1);
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      chk("redir_q_zero", q_count, 0);
      chk("redir_addr", imem_addr, 8'h80);
      chk("redir_req", imem_req, 1'b1);
      @(negedge clk);
      n0 = dut_pops.size();
      for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0, 1'b1);
      if (dut_pops.size() > n0) chk("redir_first_pc", dut_pops[n0].pc, 32'h200);
      else chk("redir_first_pc_missing", 32'd0, 32'd1);

      // Misaligned redirect onto a JAL word.
      mem[8'h80] = JAL_100;
      step(1'b0, 1'b1, 32'h202, 1'b0);
      for (int k = 0; k < 6; k++) begin
         if (id_valid) break;
         step(1'b0, 1'b0, 32'd0, 1'b0);
      end
      chk("mis_valid", id_valid, 1'b1);
      chk("mis_pc", id_pc, 32'h202);
      chk("mis_flag", id_ins_misalign, 1'b1);
      chk("mis_ins", id_ins, JAL_100);
      chk("mis_no_pred", id_predict_taken, 1'b0);

      // Reset asserted while a fetch is in flight.
      cap = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 32'd0, 1'b1);
         cap = imem_req;
         @(negedge clk);
         if (cap) break;
      end
      chk("midrst_inflight", cap, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      n0 = dut_pops.size();
      for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0, 1'b1);
      if (dut_pops.size() > n0) chk("midrst_first_pc", dut_pops[n0].pc, 32'h40);
      else chk("midrst_first_pc_missing", 32'd0, 32'd1);

`ifdef FETCH_PREDICT_EN
      // JAL +0x100 at 0x48 redirects the fetch stream to 0x148.
      mem[8'h12] = JAL_100;
      step(1'b1, 1'b0, 32'd0, 1'b1);
      n0 = dut_pops.size();
      for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 32'd0, 1'b1);
      if (dut_pops.size() >= n0 + 4) begin
         chk("jal_seq0", dut_pops[n0].pc, 32'h40);
         chk("jal_seq1", dut_pops[n0+1].pc, 32'h44);
         chk("jal_seq2", dut_pops[n0+2].pc, 32'h48);
         chk("jal_pred", dut_pops[n0+2].pred, 1'b1);
         chk("jal_seq3", dut_pops[n0+3].pc, 32'h148);
         for (int j = n0; j < dut_pops.size(); j++) chk("jal_no_4c", dut_pops[j].pc != 32'h4C, 1'b1);
      end else begin
         chk("jal_pop_count", dut_pops.size() - n0, 4);
      end
`endif

      // Randomized traffic against the reference model.
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
         if (i % 5 == 0) mem[i][6:0] = 7'b1101111;
         if (i % 7 == 0) mem[i][6:0] = 7'b1100011;
      end
      step(1'b1, 1'b0, 32'd0, 1'b1);
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6, $urandom, $urandom_range(0, 9) < 7);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000040, meaning the PC loaded on reset.
REQ-002 SHALL have parameter IMEM_AW, default 8, meaning the imem word-address width.
REQ-003 SHALL have parameter QDEPTH, default 4, meaning fetch-queue entries (power of two, >=2).
REQ-004 SHALL have ports: clk input 1, the single clock, all logic on posedge; rst input 1, synchronous active-high reset.
REQ-005 SHALL have ports: redirect input 1, a resolved mispredict or trap from a later stage; redirect_target input 32, the new PC.
REQ-006 SHALL have ports: imem_req output 1, read strobe; imem_addr output IMEM_AW, equal to pc[IMEM_AW+1:2]; imem_data input 32, valid exactly one cycle after imem_req.
REQ-007 SHALL have ports: id_ready input 1, decode accepts the head entry; id_valid output 1, the head entry is valid.
REQ-008 SHALL have ports: id_pc output 32; id_ins output 32; id_ins_misalign output 1; id_predict_taken output 1; these are the head entry fields.
REQ-009 SHALL have port q_count output $clog2(QDEPTH)+1, the current queue occupancy.

Function
REQ-010 SHALL issue imem_req in a cycle iff !rst && !redirect && (q_count + inflight) < QDEPTH, where inflight is 1 if a request was issued last cycle and not squashed.
REQ-011 SHALL advance pc to pc+4 (32-bit wrap) on each issued request, except where REQ-014 or REQ-015 apply.
REQ-012 SHALL push {pc_of_request, imem_data, misalign, predict} into the queue in the cycle the response returns, unless that response is squashed.
REQ-013 SHALL pop the head when id_valid && id_ready; a push and a pop in the same cycle SHALL leave q_count unchanged, and the queue SHALL never overflow or underflow.
REQ-014 SHALL, on redirect, set pc <= redirect_target, set q_count <= 0, and squash any in-flight response, with zero bubbles beyond the redirect cycle; redirect SHALL override every other event, including pop, push and prediction.
REQ-015 SHALL, on a non-squashed response predicted taken, set pc <= predict target and squash the request issued in that same cycle, costing a one-entry bubble.
REQ-016 SHALL set misalign = (pc_of_request[1:0] != 2'b00); a misaligned entry SHALL still be fetched from the truncated word address and SHALL never be predicted taken.
REQ-017 SHALL present the head fields from registered storage; id_valid SHALL equal (q_count != 0).
REQ-018 SHALL hold the head fields stable while id_valid && !id_ready.

Reset
REQ-019 SHALL, while rst is high: pc = RESET_PC, q_count = 0, inflight = 0, imem_req = 0, id_valid = 0, and id_predict_taken = 0.
REQ-020 SHALL issue the first request, with imem_addr = RESET_PC[IMEM_AW+1:2], in the first cycle after rst deasserts.
REQ-021 SHALL discard a response whose request preceded an rst assertion, including a reset asserted mid-flight.

Configuration
REQ-022 SHALL compile in static prediction when macro FETCH_PREDICT_EN is defined: JAL (opcode 1101111) is always predicted taken to pc+J-imm, and a B-type (opcode 1100011) with negative B-imm is predicted taken to pc+B-imm.
REQ-023 SHALL, without FETCH_PREDICT_EN, force predict to 0 and omit the REQ-015 path entirely.

Verification
REQ-024 SHALL check reset release with id_ready=1: imem_addr is 0x10, then 0x11, then 0x12; id_pc is 0x40, then 0x44, in consecutive cycles.
REQ-025 SHALL check id_ready=0 for 10 cycles with QDEPTH=4: q_count saturates at 4, imem_req stays 0, and no entry is lost or duplicated on resume.
REQ-026 SHALL check redirect=1 with target 0x200 while the queue holds 3 entries: next cycle q_count=0, imem_addr=0x80, and the stale response is never visible.
REQ-027 SHALL check, with FETCH_PREDICT_EN, imem returning JAL +0x100 at pc 0x48: the next valid entry after 0x48 is pc 0x148 with id_predict_taken=1 on 0x48, and 0x4C never appears.
REQ-028 SHALL check redirect_target 0x202: the entry has id_ins_misalign=1 and id_predict_taken=0 even for a JAL word.
REQ-029 SHALL check push and pop in the same cycle at q_count=QDEPTH-1 and at q_count=1: q_count is unchanged and the data order is preserved.
